// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer request path and the buzzer driver:
// FSM states, beep-type encoding, default timing and counter sizing helpers.
package buzzer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StGap
  } buzz_state_e;

  localparam logic BEEP_SHORT = 1'b0;
  localparam logic BEEP_LONG  = 1'b1;

  // Defaults shared with the driver so both agree on tone period and beep lengths.
  localparam int unsigned DEF_PERIOD_CYC = 12500;
  localparam int unsigned DEF_SHORT_PER  = 4;
  localparam int unsigned DEF_LONG_PER   = 255;
  localparam int unsigned DEF_GUARD_CYC  = 8;
  localparam int unsigned DEF_GAP_CYC    = 50000;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold any value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/buzzer_req_fifo.sv
// Small 1-bit synchronous FIFO with circular pointers and an occupancy counter.
// Depth must be a power of two (pointers wrap naturally), minimum 2.
module buzzer_req_fifo #(
  parameter int unsigned  Depth = 4,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            wdata_i,
  input  logic            pop_i,
  output logic            rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/buzzer_req_ctrl.sv
// Request sequencer for the buzzer driver: queues short/long beep events, issues one
// SEL/EN handshake at a time, times the beep window and enforces a silent gap.
module buzzer_req_ctrl
  import buzzer_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned SHORT_PER  = DEF_SHORT_PER,
  parameter int unsigned LONG_PER   = DEF_LONG_PER,
  parameter int unsigned GUARD_CYC  = DEF_GUARD_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic CLK_LOW,
  input  logic RST_N,
  input  logic KEY_BEEP,
  input  logic ERR_BEEP,
  input  logic BEEP_MUTE,
  output logic BUZZER_EN,
  output logic BUZZER_SEL,
  output logic BUSY,
  output logic REQ_DROP
);

  localparam int unsigned ShortWin = SHORT_PER * PERIOD_CYC + GUARD_CYC;
  localparam int unsigned LongWin  = LONG_PER * PERIOD_CYC + GUARD_CYC;
  localparam int unsigned CntW     = cnt_width(max_u(max_u(LongWin, ShortWin), GAP_CYC));
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  buzz_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                strb2_q, strb2_d;
  logic                sel_q, sel_d;
  logic                en_q, en_d;
  logic                drop_q, drop_d;

  logic                fifo_push, fifo_pop, fifo_wdata, fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count;
  logic                push_req;

  buzzer_req_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_LOW),
    .rst_ni  (RST_N),
    .flush_i (BEEP_MUTE),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A simultaneous key and error event collapses to one long request.
  always_comb begin
    push_req   = KEY_BEEP | ERR_BEEP;
    fifo_wdata = ERR_BEEP ? BEEP_LONG : BEEP_SHORT;
    fifo_push  = push_req & ~BEEP_MUTE & (~fifo_full | fifo_pop);
    drop_d     = (push_req & ~fifo_push) | (KEY_BEEP & ERR_BEEP);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strb2_d  = strb2_q;
    sel_d    = sel_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        // The type register drives SEL directly, so SEL is stable throughout SETUP.
        if (!fifo_empty && !BEEP_MUTE) begin
          fifo_pop = 1'b1;
          sel_d    = fifo_rdata;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        strb2_d = 1'b0;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (!strb2_q) begin
          strb2_d = 1'b1;
        end else begin
          strb2_d = 1'b0;
          cnt_d   = (sel_q == BEEP_LONG) ? CntW'(LongWin) : CntW'(ShortWin);
          state_d = StWait;
        end
      end
      StWait: begin
        // Mute is ignored here: the driver cannot be stopped mid-beep.
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = CntW'(GAP_CYC);
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        strb2_d = 1'b0;
        state_d = StIdle;
      end
    endcase
    en_d = (state_d == StStrobe);
  end

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      strb2_q <= 1'b0;
      sel_q   <= BEEP_SHORT;
      en_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb2_q <= strb2_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
    end
  end

  assign BUZZER_EN  = en_q;
  assign BUZZER_SEL = sel_q;
  assign REQ_DROP   = drop_q;
  assign BUSY       = (state_q != StIdle) || (fifo_count != '0);

endmodule
